// File: rtl/sr_latch_bank_pkg.sv
// sr_pkg: shared mode constants and command encodings for the sr_latch_bank slice
package sr_pkg;
  localparam int SR_MODE_RDOM   = 0;
  localparam int SR_MODE_SDOM   = 1;
  localparam int SR_MODE_HOLD   = 2;
  localparam int SR_MODE_TOGGLE = 3;
  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_BOTH = 2'b11
  } cmd_e;
endpackage

// File: rtl/sr_filt_cell.sv
// sr_filt_cell: one glitch-filtered set/reset channel with change/error pulses
// SR_LATCH_BANK_STICKY_ERR_EN adds err_clr/err_sticky
module sr_filt_cell
  import sr_pkg::*;
#(
  parameter int   FILT_CYCLES = 2,
  parameter int   MODE        = SR_MODE_RDOM,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic reset,
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
  input  logic err_clr,
  output logic err_sticky,
`endif
  output logic q,
  output logic chg,
  output logic err
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILT_CYCLES);
  cmd_e cmd, last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic apply, both_v, nq, q_q, q_d, chg_q, err_q, err_d;
  always_comb begin
    cmd = cmd_e'({set, reset});
    cnt_d = (cmd == CMD_IDLE) ? '0 :
            (cmd != last_q) ? CW'(1) :
            (cnt_q == FMAX) ? FMAX : cnt_q + 1'b1;
    // a run that is already saturated has been applied once; never re-apply it
    apply = (cnt_d == FMAX) && ((cnt_q != FMAX) || (cmd != last_q));
    both_v = (MODE == SR_MODE_RDOM) ? 1'b0 :
             (MODE == SR_MODE_SDOM) ? 1'b1 :
             (MODE == SR_MODE_HOLD) ? q_q : ~q_q;
    nq = (cmd == CMD_SET) ? 1'b1 : (cmd == CMD_RST) ? 1'b0 : both_v;
    q_d = apply ? nq : q_q;
    err_d = apply && (cmd == CMD_BOTH) && (MODE != SR_MODE_TOGGLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= CMD_IDLE;
      q_q    <= INIT;
      chg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= cmd;
      q_q    <= q_d;
      chg_q  <= q_d != q_q;
      err_q  <= err_d;
    end
  end
  assign q   = q_q;
  assign chg = chg_q;
  assign err = err_q;
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
  logic stk_q;
  always_ff @(posedge clk) begin
    if (rst) stk_q <= 1'b0;
    else     stk_q <= err_d | (stk_q & ~err_clr);
  end
  assign err_sticky = stk_q;
`endif
endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: N-channel clocked set/reset bank with glitch filter and set=reset resolution
// SR_LATCH_BANK_STICKY_ERR_EN adds per-channel err_clr input and err_sticky output
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int           N           = 4,
  parameter int           FILT_CYCLES = 2,
  parameter int           MODE        = SR_MODE_RDOM,
  parameter logic [N-1:0] INIT        = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] set,
  input  logic [N-1:0] reset,
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
  input  logic [N-1:0] err_clr,
  output logic [N-1:0] err_sticky,
`endif
  output logic [N-1:0] q,
  output logic [N-1:0] qb,
  output logic [N-1:0] chg,
  output logic [N-1:0] err
);
  if (N < 1 || N > 32 || FILT_CYCLES < 1 || FILT_CYCLES > 15 || MODE < 0 || MODE > 3) begin : g_bad
    $error("sr_latch_bank: invalid parameter N/FILT_CYCLES/MODE");
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    sr_filt_cell #(
      .FILT_CYCLES(FILT_CYCLES),
      .MODE       (MODE),
      .INIT       (INIT[i])
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .set       (set[i]),
      .reset     (reset[i]),
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
      .err_clr   (err_clr[i]),
      .err_sticky(err_sticky[i]),
`endif
      .q         (q[i]),
      .chg       (chg[i]),
      .err       (err[i])
    );
  end
  assign qb = ~q;
endmodule

// File: tb/tb_sr_latch_bank.sv
// tb_sr_latch_bank: directed checks over five parameterisations of sr_latch_bank
module tb_sr_latch_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] s[5], r[5], q[5], qb[5], chg[5], err[5];
  logic [3:0] clr[5], stk[5];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  sr_latch_bank #(.N(4), .FILT_CYCLES(2), .MODE(0), .INIT(4'b0000)) d0 (
    .clk(clk), .rst(rst), .set(s[0]), .reset(r[0]),
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
    .err_clr(clr[0]), .err_sticky(stk[0]),
`endif
    .q(q[0]), .qb(qb[0]), .chg(chg[0]), .err(err[0]));
  sr_latch_bank #(.N(4), .FILT_CYCLES(2), .MODE(1), .INIT(4'b0000)) d1 (
    .clk(clk), .rst(rst), .set(s[1]), .reset(r[1]),
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
    .err_clr(clr[1]), .err_sticky(stk[1]),
`endif
    .q(q[1]), .qb(qb[1]), .chg(chg[1]), .err(err[1]));
  sr_latch_bank #(.N(4), .FILT_CYCLES(2), .MODE(2), .INIT(4'b0000)) d2 (
    .clk(clk), .rst(rst), .set(s[2]), .reset(r[2]),
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
    .err_clr(clr[2]), .err_sticky(stk[2]),
`endif
    .q(q[2]), .qb(qb[2]), .chg(chg[2]), .err(err[2]));
  sr_latch_bank #(.N(4), .FILT_CYCLES(1), .MODE(3), .INIT(4'b0000)) d3 (
    .clk(clk), .rst(rst), .set(s[3]), .reset(r[3]),
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
    .err_clr(clr[3]), .err_sticky(stk[3]),
`endif
    .q(q[3]), .qb(qb[3]), .chg(chg[3]), .err(err[3]));
  sr_latch_bank #(.N(4), .FILT_CYCLES(3), .MODE(0), .INIT(4'b1010)) d4 (
    .clk(clk), .rst(rst), .set(s[4]), .reset(r[4]),
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
    .err_clr(clr[4]), .err_sticky(stk[4]),
`endif
    .q(q[4]), .qb(qb[4]), .chg(chg[4]), .err(err[4]));

`ifndef SR_LATCH_BANK_STICKY_ERR_EN
  assign stk[0] = '0;
  assign stk[1] = '0;
  assign stk[2] = '0;
  assign stk[3] = '0;
  assign stk[4] = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 5; k++) begin
      s[k] = '0;
      r[k] = '0;
      clr[k] = '0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({q[0], qb[0], chg[0], err[0]} !== 16'h0F00) begin
      n_bad++;
      $display("FAIL reset_d0 q/qb/chg/err got %h want 0f00", {q[0], qb[0], chg[0], err[0]});
    end
    n_cmp++;
    if ({q[4], qb[4]} !== 8'hA5) begin
      n_bad++;
      $display("FAIL reset_init_d4 q/qb got %h want a5", {q[4], qb[4]});
    end
    rst = 1'b0;
  endtask

  task automatic test_set();
    s[0] = 4'b0001;
    tick();
    n_cmp++;
    if ({q[0], chg[0]} !== 8'h00) begin
      n_bad++;
      $display("FAIL set_edge1 q/chg got %h want 00", {q[0], chg[0]});
    end
    tick();
    n_cmp++;
    if ({q[0], qb[0], chg[0], err[0]} !== 16'h1E10) begin
      n_bad++;
      $display("FAIL set_edge2 q/qb/chg/err got %h want 1e10", {q[0], qb[0], chg[0], err[0]});
    end
    tick();
    n_cmp++;
    if ({q[0], chg[0]} !== 8'h10) begin
      n_bad++;
      $display("FAIL set_held q/chg got %h want 10", {q[0], chg[0]});
    end
    s[0] = 4'b0000;
    tick();
  endtask

  task automatic test_glitch();
    logic [3:0] pat;
    pat = 4'b0101;
    for (int e = 0; e < 4; e++) begin
      s[0] = {2'b00, pat[e], 1'b0};
      tick();
      n_cmp++;
      if ({q[0], chg[0]} !== 8'h10) begin
        n_bad++;
        $display("FAIL glitch_e%0d q/chg got %h want 10", e, {q[0], chg[0]});
      end
    end
    s[0] = '0;
    tick();
  endtask

  task automatic test_both();
    for (int k = 0; k < 3; k++) s[k] = 4'b0100;
    tick();
    tick();
    for (int k = 0; k < 3; k++) r[k] = 4'b0100;
    tick();
    n_cmp++;
    if ({q[0], q[1], q[2], err[0], err[1], err[2]} !== 24'h544000) begin
      n_bad++;
      $display("FAIL both_edge1 q0..2/err0..2 got %h want 544000",
               {q[0], q[1], q[2], err[0], err[1], err[2]});
    end
    tick();
    n_cmp++;
    if ({q[0], q[1], q[2]} !== 12'h144) begin
      n_bad++;
      $display("FAIL both_q q0/q1/q2 got %h want 144", {q[0], q[1], q[2]});
    end
    n_cmp++;
    if ({err[0], err[1], err[2]} !== 12'h444) begin
      n_bad++;
      $display("FAIL both_err err0/1/2 got %h want 444", {err[0], err[1], err[2]});
    end
    n_cmp++;
    if ({chg[0], chg[1], chg[2]} !== 12'h400) begin
      n_bad++;
      $display("FAIL both_chg chg0/1/2 got %h want 400", {chg[0], chg[1], chg[2]});
    end
    tick();
    n_cmp++;
    if ({err[0], err[1], err[2], q[0], q[1], q[2]} !== 24'h000144) begin
      n_bad++;
      $display("FAIL both_held err/q got %h want 000144", {err[0], err[1], err[2], q[0], q[1], q[2]});
    end
    idle_all();
    tick();
  endtask

  task automatic test_toggle();
    s[3] = 4'b1000;
    r[3] = 4'b1000;
    for (int e = 0; e < 5; e++) begin
      tick();
      n_cmp++;
      if ({q[3], chg[3], err[3]} !== ((e == 0) ? 12'h880 : 12'h800)) begin
        n_bad++;
        $display("FAIL toggle_hold_e%0d q/chg/err got %h want %h", e, {q[3], chg[3], err[3]},
                 (e == 0) ? 12'h880 : 12'h800);
      end
    end
    s[3] = '0;
    r[3] = '0;
    tick();
    n_cmp++;
    if ({q[3], chg[3]} !== 8'h80) begin
      n_bad++;
      $display("FAIL toggle_idle q/chg got %h want 80", {q[3], chg[3]});
    end
    s[3] = 4'b1000;
    r[3] = 4'b1000;
    tick();
    n_cmp++;
    if ({q[3], chg[3], err[3]} !== 12'h080) begin
      n_bad++;
      $display("FAIL toggle_again q/chg/err got %h want 080", {q[3], chg[3], err[3]});
    end
    idle_all();
    tick();
  endtask

  task automatic test_rst_mid();
    s[4] = 4'b0001;
    tick();
    tick();
    n_cmp++;
    if (q[4] !== 4'b1010) begin
      n_bad++;
      $display("FAIL rstmid_pre q got %b want 1010", q[4]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({q[4], chg[4]} !== 8'hA0) begin
      n_bad++;
      $display("FAIL rstmid_rst q/chg got %h want a0", {q[4], chg[4]});
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if ({q[4], chg[4]} !== ((e == 3) ? 8'hB1 : 8'hA0)) begin
        n_bad++;
        $display("FAIL rstmid_e%0d q/chg got %h want %h", e, {q[4], chg[4]},
                 (e == 3) ? 8'hB1 : 8'hA0);
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_sticky();
`ifdef SR_LATCH_BANK_STICKY_ERR_EN
    s[0] = 4'b0010;
    r[0] = 4'b0010;
    tick();
    tick();
    n_cmp++;
    if ({err[0], stk[0]} !== 8'h22) begin
      n_bad++;
      $display("FAIL sticky_set err/sticky got %h want 22", {err[0], stk[0]});
    end
    s[0] = '0;
    r[0] = '0;
    tick();
    tick();
    n_cmp++;
    if ({err[0], stk[0]} !== 8'h02) begin
      n_bad++;
      $display("FAIL sticky_hold err/sticky got %h want 02", {err[0], stk[0]});
    end
    s[0] = 4'b0010;
    r[0] = 4'b0010;
    tick();
    clr[0] = 4'b0010;
    tick();
    n_cmp++;
    if ({err[0], stk[0]} !== 8'h22) begin
      n_bad++;
      $display("FAIL sticky_setprio err/sticky got %h want 22", {err[0], stk[0]});
    end
    s[0] = '0;
    r[0] = '0;
    tick();
    n_cmp++;
    if (stk[0] !== 4'b0000) begin
      n_bad++;
      $display("FAIL sticky_clr sticky got %b want 0000", stk[0]);
    end
    idle_all();
    tick();
`endif
  endtask

  initial begin
    idle_all();
    test_reset();
    test_set();
    test_glitch();
    test_both();
    test_toggle();
    test_rst_mid();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
